// File: rtl/icache_pkg.sv
// Shared defaults and FSM state type for the instruction-cache line-fill engine.
package icache_pkg;

    localparam int DEF_ADDR_SIZE      = 14;
    localparam int DEF_WORD_SIZE      = 32;
    localparam int DEF_WORDS_PER_LINE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/icache_fill.sv
// I-cache line fill engine: on an L1 miss it streams one whole line from memory
// into the L1, writing words in ascending offset order so the last write validates the line.
module icache_fill
    import icache_pkg::*;
#(
    parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
    parameter int WORD_SIZE      = DEF_WORD_SIZE,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [ADDR_SIZE-1:0] fetch_addr,
    input  logic                 l1_hit,
    output logic [ADDR_SIZE-1:0] l1_addr,
    output logic                 l1_we,
    output logic [WORD_SIZE-1:0] l1_data,
    output logic                 stall,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_SIZE-1:0] mem_req_addr,
    input  logic                 mem_rsp_valid,
    input  logic [WORD_SIZE-1:0] mem_rsp_data,
    output fill_state_t          fill_state
);

    localparam int OFF    = $clog2(WORDS_PER_LINE);
    localparam int LINE_W = ADDR_SIZE - OFF;

    localparam logic [OFF:0] CNT_FULL = (OFF+1)'(WORDS_PER_LINE);
    localparam logic [OFF:0] CNT_LAST = (OFF+1)'(WORDS_PER_LINE - 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] FILL = ST_FILL;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [OFF:0]      req_cnt;
    logic [OFF:0]      rsp_cnt;
    logic [LINE_W-1:0] line_addr;

    logic miss;
    logic req_fire;
    logic rsp_take;

    // Memory request channel: a request transfers on a cycle where mem_req_valid
    // and mem_req_ready are both high; once raised, valid and address hold until
    // that transfer. Responses return in request order and are never backpressured.

    assign miss     = (state == IDLE) && fetch_valid && !l1_hit;
    assign req_fire = mem_req_valid && mem_req_ready;
    // Counter guard keeps rsp_cnt from wrapping if memory ever over-delivers.
    assign rsp_take = (state == FILL) && mem_rsp_valid && (rsp_cnt < CNT_FULL);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (miss) state_nxt = FILL;
            FILL: if (rsp_take && (rsp_cnt == CNT_LAST)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_cnt   <= '0;
            rsp_cnt   <= '0;
            line_addr <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (miss) begin
                        line_addr <= fetch_addr[ADDR_SIZE-1:OFF];
                        req_cnt   <= '0;
                        rsp_cnt   <= '0;
                    end
                end
                FILL: begin
                    // Request and response can both land in one cycle; each counter moves independently.
                    if (req_fire) req_cnt <= req_cnt + 1'b1;
                    if (rsp_take) rsp_cnt <= rsp_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        l1_addr       = fetch_addr;
        l1_we         = 1'b0;
        l1_data       = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        if (state == FILL) begin
            mem_req_valid = (req_cnt < CNT_FULL);
            mem_req_addr  = {line_addr, req_cnt[OFF-1:0]};
            l1_we         = rsp_take;
            l1_addr       = {line_addr, rsp_cnt[OFF-1:0]};
            l1_data       = mem_rsp_data;
        end
    end

    assign stall      = (state != IDLE) || (fetch_valid && !l1_hit);
    assign fill_state = fill_state_t'(state);

endmodule

// File: tb/tb_icache_fill.sv
// Bench for icache_fill: a line-valid L1 model, an in-order memory model with
// random latency/ready, and queue scoreboards for memory requests and L1 writes.
module tb_icache_fill;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int WPL = 8;
    localparam int NLINES = 1 << (AW - 3);

    logic          clk;
    logic          rst_n;
    logic          fetch_valid;
    logic [AW-1:0] fetch_addr;
    logic          l1_hit;
    logic [AW-1:0] l1_addr;
    logic          l1_we;
    logic [DW-1:0] l1_data;
    logic          stall;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    icache_pkg::fill_state_t fill_state;

    icache_fill dut (
        .clk           (clk),
        .reset         (rst_n),
        .fetch_valid   (fetch_valid),
        .fetch_addr    (fetch_addr),
        .l1_hit        (l1_hit),
        .l1_addr       (l1_addr),
        .l1_we         (l1_we),
        .l1_data       (l1_data),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_state    (fill_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- models ----------------
    logic [DW-1:0] mem_data [0:(1<<AW)-1];
    logic [DW-1:0] l1_mem   [0:(1<<AW)-1];
    bit            l1_valid [0:NLINES-1];
    bit            ref_valid[0:NLINES-1];

    assign l1_hit = l1_valid[l1_addr[AW-1:3]];

    // ---------------- scoreboard ----------------
    logic [AW-1:0]    exp_req_q[$];
    logic [AW+DW-1:0] exp_wr_q[$];
    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int last7_cyc = -100;
    logic [AW+DW-1:0] mon_wr;
    logic [AW-1:0]    mon_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (l1_we) begin
            wr_cnt++;
            if (exp_wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL l1_write_unexpected: got addr %0h data %0h expected no write", l1_addr, l1_data);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                check("l1_write", {l1_addr, l1_data}, mon_wr);
            end
            l1_mem[l1_addr] = l1_data;
            if (l1_addr[2:0] == 3'd7) begin
                l1_valid[l1_addr[AW-1:3]] = 1'b1;
                last7_cyc = cyc;
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            if (exp_req_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mem_req_unexpected: got addr %0h expected no request", mem_req_addr);
            end else begin
                mon_req = exp_req_q.pop_front();
                check("mem_req", mem_req_addr, mon_req);
            end
        end
    end

    // ---------------- memory model ----------------
    logic [AW-1:0] pend_q[$];
    int            due_q[$];
    int  mcyc = 0;
    int  last_due = 0;
    int  ready_mode = 0;   // 0: always ready, 1: toggle 1,0, 2: random
    int  lat_min = 2;
    int  lat_max = 2;
    bit  spurious = 0;
    bit  rsp_from_q = 0;
    bit  tog = 1;
    bit  m_hs;
    bit  m_used;
    logic [AW-1:0] m_addr;
    int  m_due;

    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            m_hs   = mem_req_valid && mem_req_ready;
            m_addr = mem_req_addr;
            m_used = mem_rsp_valid && rsp_from_q;
            @(posedge clk);
            #1;
            mcyc++;
            if (m_used) begin
                void'(pend_q.pop_front());
                void'(due_q.pop_front());
            end
            if (m_hs) begin
                m_due = mcyc + $urandom_range(lat_max, lat_min) - 1;
                if (m_due < last_due) m_due = last_due;
                last_due = m_due;
                pend_q.push_back(m_addr);
                due_q.push_back(m_due);
            end
            case (ready_mode)
                0: mem_req_ready = 1'b1;
                1: begin mem_req_ready = tog; tog = ~tog; end
                default: mem_req_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (spurious) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEADBEEF;
                rsp_from_q    = 1'b0;
            end else if (pend_q.size() > 0 && due_q[0] <= mcyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_data[pend_q[0]];
                rsp_from_q    = 1'b1;
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
                rsp_from_q    = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_line(input logic [AW-4:0] ln);
        logic [AW-1:0] a;
        for (int i = 0; i < WPL; i++) begin
            a = {ln, 3'(i)};
            exp_req_q.push_back(a);
            exp_wr_q.push_back({a, mem_data[a]});
        end
        ref_valid[ln] = 1'b1;
    endtask

    task automatic invalidate(input logic [AW-4:0] ln);
        ref_valid[ln] = 1'b0;
        l1_valid[ln]  = 1'b0;
    endtask

    task automatic wait_fill();
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (cyc == last7_cyc + 1)
                check("done_cycle", {stall, mem_req_valid, l1_we, l1_addr},
                      {1'b1, 1'b0, 1'b0, fetch_addr});
            if (!stall) begin
                done = 1;
                check("release_latency", 64'(cyc - last7_cyc), 64'd2);
            end else if (n > 400) begin
                done = 1;
                total++;
                bad++;
                $display("FAIL fill_timeout: stall still %0b after %0d cycles, expected 0", stall, n);
                exp_req_q.delete();
                exp_wr_q.delete();
            end
        end
        check("req_q_drained", 64'(exp_req_q.size()), 64'd0);
        check("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
    endtask

    task automatic do_fetch(input logic [AW-1:0] a);
        @(posedge clk);
        #2;
        fetch_valid = 1'b1;
        fetch_addr  = a;
        if (ref_valid[a[AW-1:3]]) begin
            @(negedge clk);
            check("hit_stall", stall, 1'b0);
            check("hit_no_req", mem_req_valid, 1'b0);
        end else begin
            push_line(a[AW-1:3]);
            wait_fill();
        end
        @(posedge clk);
        #2;
        fetch_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int base;
    int n;
    logic [AW-4:0] lines [0:5];

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr = '0;
        for (int i = 0; i < (1 << AW); i++) mem_data[i] = $urandom;
        lines[0] = 11'h008; lines[1] = 11'h020; lines[2] = 11'h240;
        lines[3] = 11'h000; lines[4] = 11'h7FF; lines[5] = 11'h155;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_l1_we", l1_we, 1'b0);
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_l1_data", l1_data, '0);
        check("rst_req_addr", mem_req_addr, '0);
        #1;
        fetch_valid = 1'b1;
        fetch_addr  = 14'h0040;
        #1;
        check("rst_miss_stall", stall, 1'b1);
        check("rst_l1_addr", l1_addr, 14'h0040);
        fetch_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // cold miss, ready always high, latency 2, then a hit in the same line
        do_fetch(14'h0040);
        do_fetch(14'h0043);

        // ready toggling
        ready_mode = 1;
        do_fetch(14'h0100);
        ready_mode = 0;

        // spurious response while idle
        @(posedge clk);
        #2;
        spurious = 1'b1;
        @(posedge clk);
        #2;
        spurious = 1'b0;
        @(negedge clk);
        check("spurious_l1_we", l1_we, 1'b0);
        check("spurious_l1_data", l1_data, '0);

        // fetch address changes mid-fill
        invalidate(11'h008);
        invalidate(11'h240);
        @(posedge clk);
        #2;
        fetch_valid = 1'b1;
        fetch_addr  = 14'h0040;
        push_line(11'h008);
        repeat (3) @(posedge clk);
        #2;
        fetch_addr = 14'h1200;
        push_line(11'h240);
        wait_fill();
        @(posedge clk);
        #2;
        fetch_valid = 1'b0;
        do_fetch(14'h0044);
        do_fetch(14'h1207);

        // reset after four responses
        invalidate(11'h008);
        @(posedge clk);
        #2;
        fetch_valid = 1'b1;
        fetch_addr  = 14'h0040;
        push_line(11'h008);
        ref_valid[11'h008] = 1'b0;
        base = wr_cnt;
        n = 0;
        while (wr_cnt < base + 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_4_writes", 64'(wr_cnt >= base + 4), 64'd1);
        #1;
        rst_n = 1'b0;
        exp_req_q.delete();
        exp_wr_q.delete();
        #1;
        check("abort_l1_we", l1_we, 1'b0);
        check("abort_req_valid", mem_req_valid, 1'b0);
        check("abort_l1_data", l1_data, '0);
        check("abort_req_addr", mem_req_addr, '0);
        check("abort_l1_addr", l1_addr, 14'h0040);
        check("abort_stall", stall, 1'b1);
        fetch_valid = 1'b0;
        #1;
        check("abort_stall_nofetch", stall, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        do_fetch(14'h0040);

        // randomized traffic
        ready_mode = 2;
        lat_min = 1;
        lat_max = 4;
        for (int k = 0; k < 24; k++) begin
            logic [AW-4:0] ln;
            ln = lines[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) invalidate(ln);
            do_fetch({ln, 3'($urandom_range(0, 7))});
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
